rv_top_wrap: RTL and testbench

// - FPGA top-level I/O shell of the mini RISC-V board design: 8N1 UART RX/TX, 8-digit 7-seg display, 16 LEDs, debug register view.
// - A 96-bit logic-locking key gates all functional I/O; wrong key = outputs held inert.
// - Sits directly under board pins; core datapath is outside this block's scope.

---
 rtl/rv_top_pkg.sv | 48 ++++
 rtl/rv_top_wrap_uart_rx.sv | 85 ++++++++
 rtl/rv_top_wrap.sv | 184 ++++++++++++++++++
 tb/tb_rv_top_wrap.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_top_pkg.sv
// Shared constants and helpers for the rv_top_wrap board I/O shell:
// golden key, debug selects, RX/TX state types, active-low hex to 7-seg.
package rv_top_pkg;

    localparam logic [95:0] KEY_GOLDEN =
        96'h3cf3cf3cf3cf_30c30c_bae_3cf;

    typedef enum logic [4:0] {
        DBG_DATA  = 5'd0,
        DBG_LAST  = 5'd1,
        DBG_COUNT = 5'd2,
        DBG_FERR  = 5'd3,
        DBG_LOCK  = 5'd4
    } dbg_sel_e;

    typedef enum logic [1:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE, TX_START, TX_DATA, TX_STOP
    } tx_state_e;

    // Segment order {g,f,e,d,c,b,a}, 0 = lit.
    function automatic logic [6:0] hex_to_7seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/rv_top_wrap_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer plus RX FSM.
// Ports: clk, rst (sync, active-high), rx_i serial in;
// byte_o received byte, byte_valid_o / frame_err_pulse_o 1-cycle pulses.
module rv_top_wrap_uart_rx
    import rv_top_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_pulse_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]    sync_q;
    logic          rx_s;
    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;

    assign rx_s   = sync_q[1];
    assign byte_o = sh_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 2'b11;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
        end else begin
            sync_q  <= {sync_q[0], rx_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q + 1'b1;
        bit_d             = bit_q;
        sh_d              = sh_q;
        byte_valid_o      = 1'b0;
        frame_err_pulse_o = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (!rx_s) state_d = RX_START;
            end
            RX_START: begin
                // mid-start re-check rejects glitches
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    sh_d  = {rx_s, sh_q[7:1]};
                    bit_d = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end
            end
            default: begin
                if (cnt_q == LAST) begin
                    cnt_d             = '0;
                    state_d           = RX_IDLE;
                    byte_valid_o      = rx_s;
                    frame_err_pulse_o = !rx_s;
                end
            end
        endcase
    end

endmodule

// File: rtl/rv_top_wrap.sv
// Board I/O shell: UART RX/echo TX, 8-digit 7-seg scan, LEDs, debug view.
// Ports: clk, Rst (sync, active-high), debug, debug_input[4:0], prog, rx,
// key[95:0]; outputs tx, clk_out (clk/2), sev_out[6:0], an[7:0], led[15:0].
// Define RV_TOP_KEY_LOCK_EN to gate all functional I/O on the 96-bit key.
module rv_top_wrap
    import rv_top_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int REFRESH_BITS = 17
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic        debug,
    input  logic [4:0]  debug_input,
    input  logic        prog,
    input  logic        rx,
    input  logic [95:0] key,
    output logic        tx,
    output logic        clk_out,
    output logic [6:0]  sev_out,
    output logic [7:0]  an,
    output logic [15:0] led
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic        unlocked;
    logic [7:0]  rx_byte;
    logic        rx_valid, rx_ferr, valid, ferr, echo_go;
    logic        clk_out_q, frame_err_q;
    logic [31:0] data_word_q, rx_count_q, dbg_word, disp_word;
    logic [7:0]  last_byte_q, an_q;
    logic [6:0]  sev_q;
    logic [15:0] led_q;
    logic [REFRESH_BITS-1:0] scan_q;
    logic [2:0]  dig;
    logic [4:0]  nib_idx;
    logic [3:0]  nib;

    tx_state_e     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_sh_q, tx_sh_d;
    logic          tx_q, tx_d;

`ifdef RV_TOP_KEY_LOCK_EN
    logic unlocked_q;
    always_ff @(posedge clk) begin
        if (Rst) unlocked_q <= 1'b0;
        else     unlocked_q <= (key == KEY_GOLDEN);
    end
    assign unlocked = unlocked_q;
`else
    logic unused_key;
    assign unused_key = ^key;
    assign unlocked   = 1'b1;
`endif

    rv_top_wrap_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk               (clk),
        .rst               (Rst),
        .rx_i              (rx),
        .byte_o            (rx_byte),
        .byte_valid_o      (rx_valid),
        .frame_err_pulse_o (rx_ferr)
    );

    // a locked shell discards everything the receiver produces
    assign valid   = rx_valid & unlocked;
    assign ferr    = rx_ferr & unlocked;
    assign echo_go = valid & ~prog;

    always_comb begin
        dbg_word = '0;
        case (dbg_sel_e'(debug_input))
            DBG_DATA:  dbg_word = data_word_q;
            DBG_LAST:  dbg_word = {24'h0, last_byte_q};
            DBG_COUNT: dbg_word = rx_count_q;
            DBG_FERR:  dbg_word = {31'h0, frame_err_q};
            DBG_LOCK:  dbg_word = {31'h0, unlocked};
            default:   dbg_word = '0;
        endcase
    end

    assign disp_word = debug ? dbg_word : data_word_q;
    assign dig       = scan_q[REFRESH_BITS-1 -: 3];
    assign nib_idx   = {dig, 2'b00};
    assign nib       = disp_word[nib_idx +: 4];

    always_ff @(posedge clk) begin
        if (Rst) begin
            clk_out_q   <= 1'b0;
            scan_q      <= '0;
            data_word_q <= '0;
            last_byte_q <= '0;
            rx_count_q  <= '0;
            frame_err_q <= 1'b0;
            an_q        <= 8'hFE;
            sev_q       <= hex_to_7seg(4'h0);
            led_q       <= '0;
        end else begin
            clk_out_q <= ~clk_out_q;
            scan_q    <= scan_q + 1'b1;
            if (valid) begin
                last_byte_q <= rx_byte;
                rx_count_q  <= rx_count_q + 1'b1;
                if (prog) data_word_q <= {data_word_q[23:0], rx_byte};
            end
            if (ferr) frame_err_q <= 1'b1;
            an_q  <= unlocked ? ~(8'd1 << dig) : 8'hFF;
            sev_q <= unlocked ? hex_to_7seg(nib) : 7'h7F;
            led_q <= unlocked ? {unlocked, prog, debug, frame_err_q,
                                 4'h0, last_byte_q} : 16'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            tx_q       <= tx_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_d       = tx_q;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                if (echo_go) begin
                    tx_sh_d    = rx_byte;
                    tx_d       = 1'b0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt_q == LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_d       = tx_sh_q[0];
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_d       = 1'b1;
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_sh_d  = tx_sh_q >> 1;
                        tx_d     = tx_sh_q[1];
                        tx_bit_d = tx_bit_q + 1'b1;
                    end
                end
            end
            default: begin
                if (tx_cnt_q == LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_IDLE;
                end
            end
        endcase
    end

    assign tx      = tx_q | ~unlocked;
    assign clk_out = clk_out_q;
    assign an      = an_q;
    assign sev_out = sev_q;
    assign led     = led_q;

endmodule

// File: tb/tb_rv_top_wrap.sv
// Directed/randomized bench for rv_top_wrap with a behavioural model
// of the UART byte stream, data word, counters and display.
module tb_rv_top_wrap;
    localparam int CPB = 16;
    localparam int RB  = 6;
    localparam logic [95:0] GOLD = 96'h3cf3cf3cf3cf_30c30c_bae_3cf;

    logic        clk = 1'b0;
    logic        Rst = 1'b1;
    logic        debug = 1'b0;
    logic [4:0]  debug_input = 5'd0;
    logic        prog = 1'b0;
    logic        rx = 1'b1;
    logic [95:0] key = GOLD;
    logic        tx, clk_out;
    logic [6:0]  sev_out;
    logic [7:0]  an;
    logic [15:0] led;

    int checks = 0;
    int failures = 0;
    bit tx_low_seen = 0;

    logic [31:0] m_word, m_count;
    logic [7:0]  m_last;
    logic        m_ferr;

    always #5 clk = ~clk;

    rv_top_wrap #(.CLKS_PER_BIT(CPB), .REFRESH_BITS(RB)) dut (
        .clk(clk), .Rst(Rst), .debug(debug), .debug_input(debug_input),
        .prog(prog), .rx(rx), .key(key), .tx(tx), .clk_out(clk_out),
        .sev_out(sev_out), .an(an), .led(led)
    );

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[n];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                if (tx === 1'b0) tx_low_seen = 1;
            end
        end
        rx = 1'b1;
    endtask

    task automatic recv_tx(output logic [7:0] b, output logic ok);
        int n;
        ok = 1'b0;
        b  = '0;
        n  = 0;
        while (tx !== 1'b0 && n < 40 * CPB) begin
            @(negedge clk);
            n++;
        end
        if (tx !== 1'b0) return;
        cyc(CPB / 2);
        if (tx !== 1'b0) return;
        for (int i = 0; i < 8; i++) begin
            cyc(CPB);
            b[i] = tx;
        end
        cyc(CPB);
        ok = (tx === 1'b1);
    endtask

    task automatic check_digit(input int i, input logic [3:0] n,
                               input string tag);
        int w;
        logic [7:0] want;
        want = ~(8'd1 << i);
        w = 0;
        while (an !== want && w < 256) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_an"}, {24'h0, an}, {24'h0, want});
        chk(tag, {25'h0, sev_out}, {25'h0, seg7(n)});
    endtask

    task automatic check_word(input logic [31:0] wd, input string tag);
        for (int i = 0; i < 8; i++)
            check_digit(i, wd[4*i +: 4], tag);
    endtask

    task automatic check_led(input string tag);
        logic [15:0] e;
        e = {1'b1, prog, debug, m_ferr, 4'h0, m_last};
        chk(tag, {16'h0, led}, {16'h0, e});
    endtask

    task automatic model_byte(input logic [7:0] b);
        m_count = m_count + 1;
        m_last  = b;
        if (prog) m_word = {m_word[23:0], b};
    endtask

    task automatic model_reset();
        m_word  = '0;
        m_count = '0;
        m_last  = '0;
        m_ferr  = 1'b0;
    endtask

    task automatic echo_byte(input logic [7:0] b, input string tag);
        logic [7:0] got;
        logic ok;
        fork
            send_frame(b, 1'b1);
            recv_tx(got, ok);
        join
        chk({tag, "_frame"}, {31'h0, ok}, 32'h1);
        chk({tag, "_data"}, {24'h0, got}, {24'h0, b});
        model_byte(b);
        cyc(4);
    endtask

    initial begin
        logic [7:0] b;
        model_reset();

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", {31'h0, tx}, 32'h1);
        chk("rst_clk_out", {31'h0, clk_out}, 32'h0);
        chk("rst_an", {24'h0, an}, 32'hFE);
        chk("rst_sev", {25'h0, sev_out}, 32'h40);
        chk("rst_led", {16'h0, led}, 32'h0);
        @(negedge clk);
        Rst = 1'b0;
        cyc(4);
        check_led("led_idle");

        // echo path: 0x55 first, then random bytes
        echo_byte(8'h55, "echo55");
        check_led("led_echo55");
        debug = 1'b1;
        debug_input = 5'd2;
        cyc(3);
        check_word(32'd1, "cnt_one");
        debug = 1'b0;
        debug_input = 5'd0;
        for (int k = 0; k < 2; k++) begin
            echo_byte(8'($urandom), "echo_rnd");
            check_led("led_echo_rnd");
        end

        // program mode: bytes shift into the data word, no echo
        prog = 1'b1;
        cyc(2);
        tx_low_seen = 0;
        send_frame(8'hDE, 1'b1); model_byte(8'hDE); cyc(4);
        send_frame(8'hAD, 1'b1); model_byte(8'hAD); cyc(4);
        send_frame(8'hBE, 1'b1); model_byte(8'hBE); cyc(4);
        send_frame(8'hEF, 1'b1); model_byte(8'hEF); cyc(4);
        chk("prog_no_echo", {31'h0, tx_low_seen}, 32'h0);
        check_word(32'hDEADBEEF, "dw_deadbeef");
        check_digit(7, 4'hD, "dig7");
        chk("dig7_is_d", {25'h0, sev_out}, 32'h21);
        for (int k = 0; k < 4; k++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1);
            model_byte(b);
            cyc(4);
        end
        check_word(m_word, "dw_rand");
        check_led("led_prog");
        prog = 1'b0;
        cyc(2);

        // framing error: sticky flag, byte dropped
        tx_low_seen = 0;
        send_frame(8'($urandom), 1'b0);
        cyc(2 * CPB);
        m_ferr = 1'b1;
        chk("ferr_no_echo", {31'h0, tx_low_seen}, 32'h0);
        chk("ferr_led12", {31'h0, led[12]}, 32'h1);
        check_led("led_ferr");
        echo_byte(8'($urandom), "echo_after_ferr");
        check_led("led_ferr_sticky");

        // debug selects
        debug = 1'b1;
        debug_input = 5'd2; cyc(3); check_word(m_count, "dbg_count");
        debug_input = 5'd1; cyc(3); check_word({24'h0, m_last}, "dbg_last");
        debug_input = 5'd3; cyc(3); check_word(32'h1, "dbg_ferr");
        debug_input = 5'd4; cyc(3); check_word(32'h1, "dbg_unlock");
        debug_input = 5'd9; cyc(3); check_word(32'h0, "dbg_nine");
        debug_input = 5'($urandom_range(31, 5));
        cyc(3);
        check_word(32'h0, "dbg_rnd_hi");
        debug_input = 5'd0; cyc(3); check_word(m_word, "dbg_data");
        debug = 1'b0;
        cyc(2);

`ifdef RV_TOP_KEY_LOCK_EN
        // wrong key: outputs inert, RX bytes discarded
        key = '0;
        cyc(3);
        chk("lock_an", {24'h0, an}, 32'hFF);
        chk("lock_sev", {25'h0, sev_out}, 32'h7F);
        chk("lock_led", {16'h0, led}, 32'h0);
        tx_low_seen = 0;
        send_frame(8'hA5, 1'b1);
        cyc(4);
        chk("lock_no_echo", {31'h0, tx_low_seen}, 32'h0);
        key = GOLD;
        @(posedge clk); #1;
        chk("unlock_1cyc", {24'h0, an}, 32'hFF);
        @(posedge clk); #1;
        chk("unlock_2cyc", {31'h0, an !== 8'hFF}, 32'h1);
        cyc(2);
        check_led("led_relock");
        debug = 1'b1;
        debug_input = 5'd2;
        cyc(3);
        check_word(m_count, "lock_count_kept");
        debug = 1'b0;
        debug_input = 5'd0;
        cyc(2);
`else
        // key ignored in this build
        key = '0;
        cyc(3);
        chk("nolock_an_live", {31'h0, an !== 8'hFF}, 32'h1);
        check_led("nolock_led");
        echo_byte(8'($urandom), "nolock_echo");
        key = GOLD;
        cyc(2);
`endif

        // reset in the middle of an echo frame
        b = 8'($urandom);
        fork
            send_frame(b, 1'b1);
            begin
                int n;
                n = 0;
                while (tx !== 1'b0 && n < 40 * CPB) begin
                    @(negedge clk);
                    n++;
                end
                chk("midtx_started", {31'h0, tx}, 32'h0);
                cyc(5);
                Rst = 1'b1;
                @(posedge clk); #1;
                chk("midtx_rst_tx", {31'h0, tx}, 32'h1);
                chk("midtx_rst_an", {24'h0, an}, 32'hFE);
                chk("midtx_rst_clk", {31'h0, clk_out}, 32'h0);
                chk("midtx_rst_sev", {25'h0, sev_out}, 32'h40);
            end
        join
        @(negedge clk);
        Rst = 1'b0;
        model_reset();
        cyc(4);
        check_led("led_after_rst");
        chk("tx_idle_after_rst", {31'h0, tx}, 32'h1);
        check_word(32'h0, "dw_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
